mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, SHALL be the maximum WAIT cycles before a memory timeout error.
REQ-002 clk  in  1  SHALL be the single clock; every flop SHALL update on its rising edge.
REQ-003 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-004 valid  in  1  SHALL mean an EX/MEM instruction is present.
REQ-005 addr  in  16  SHALL be the byte address, the ALU result from execute.
REQ-006 wdata  in  16  SHALL be the store data from execute.
REQ-007 MemRead  in  1  SHALL request a load; MemWrite  in  1  SHALL request a store.
REQ-008 mem_rd, mem_wr  out  1 each  SHALL be the memory read/write strobes.
REQ-009 mem_addr, mem_wdata  out  16 each  SHALL be the registered request address and data.
REQ-010 mem_rdata  in  16, mem_done  in  1, mem_err  in  1  SHALL be the memory response.
REQ-011 stall_out  out  1  SHALL freeze IF/ID/EX and hold EX/MEM.
REQ-012 rdata_out  out  16, rdata_valid  out  1  SHALL carry load data to MEM/WB.
REQ-013 err  out  1  SHALL be the sticky stage error.

Function
REQ-014 States SHALL be IDLE, REQ, WAIT, DONE and ERR.
REQ-015 IDLE, valid with exactly one of MemRead/MemWrite and addr[0]=0: capture addr/wdata/type, assert stall_out in the same cycle, go to REQ.
REQ-016 IDLE, valid with neither strobe: pass-through, stall_out=0, no request, state stays IDLE.
REQ-017 IDLE, valid with both strobes or addr[0]=1: no request issued; err set next cycle; go to ERR.
REQ-018 REQ: drive mem_rd or mem_wr high for exactly this one cycle from the captured registers; stall_out=1; go to WAIT.
REQ-019 WAIT: stall_out=1; strobes low; mem_done sampled only in WAIT.
REQ-020 WAIT with mem_done=1, mem_err=0: capture mem_rdata if the access is a load; go to DONE.
REQ-021 WAIT with mem_done=1 and mem_err=1: go to ERR.
REQ-022 A WAIT counter SHALL clear on REQ entry; when it reaches TIMEOUT_CYCLES-1 without mem_done, go to ERR.
REQ-023 A mem_done arriving in the same cycle the counter reaches TIMEOUT_CYCLES-1 SHALL win, giving a normal completion.
REQ-024 DONE: stall_out=0; rdata_valid=1 for loads only, one cycle; rdata_out held until the next load completes; go to IDLE.
REQ-025 ERR: stall_out=1 permanently; strobes low; err=1; exit only by rst.
REQ-026 Minimum access latency: presented cycle N, strobe at N+1, earliest done at N+2, DONE at N+3, pipeline advances at end of N+3.
REQ-027 mem_done asserted outside WAIT SHALL be ignored.
REQ-028 Address arithmetic: none; addr SHALL pass unmodified with 16-bit wrap inherited from upstream.

Reset
REQ-029 rst SHALL force: state IDLE, counter 0, mem_rd=mem_wr=0, mem_addr=mem_wdata=0, rdata_out=0, rdata_valid=0, err=0.
REQ-030 stall_out SHALL be 0 during any reset cycle.
REQ-031 rst asserted mid-access (REQ/WAIT/DONE/ERR) SHALL abort, with strobes low from the next edge; a late mem_done SHALL be ignored.

Structure
REQ-032 State encodings and the TIMEOUT_CYCLES default SHALL live in a shared constants include, mem_stage_defs.
REQ-033 The FSM and WAIT counter SHALL be one sub-module, mem_req_fsm; the datapath registers SHALL be in mem_stage.

Verification
REQ-034 Load, addr=16'h0010, mem_done 2 cycles after the strobe, mem_rdata=16'hBEEF -> one mem_rd pulse, stall high for 4 cycles, rdata_valid with 16'hBEEF, err=0.
REQ-035 Store, addr=16'h0020, wdata=16'h1234 -> mem_wr one cycle, mem_wdata=16'h1234, rdata_valid never set.
REQ-036 Load at addr=16'h0011 -> no strobe, err=1 next cycle, stall_out stuck high until rst.
REQ-037 TIMEOUT_CYCLES=4, mem_done never -> ERR after 4 WAIT cycles; repeat with mem_done on the 4th WAIT cycle -> normal DONE.
REQ-038 rst in WAIT, then mem_done the cycle after -> state IDLE, no rdata_valid, all outputs at reset values.
REQ-039 Back-to-back: a non-memory instruction, then a load, then a store -> zero stall on the first, each access completes separately, strobes never overlap.

Source files
------------

// File: rtl/mem_stage_defs.sv
// Shared constants for the memory stage: FSM state encodings, the default
// WAIT timeout and the access legality check used when an instruction is
// accepted from EX/MEM.
package mem_stage_defs;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam int TIMEOUT_CYCLES_DEFAULT = 64;

  // An access is legal when exactly one of load/store is requested and the
  // halfword address is aligned.
  function automatic logic access_ok(input logic rd, input logic wr, input logic addr_lsb);
    return (rd ^ wr) & ~addr_lsb;
  endfunction

endpackage

// File: rtl/mem_req_fsm.sv
// Request sequencer for the memory stage: IDLE/REQ/WAIT/DONE/ERR FSM plus the
// WAIT-cycle timeout counter.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   valid, mem_read,
//   mem_write, addr_lsb   EX/MEM instruction qualifiers
//   mem_done, mem_err     memory response (only honoured in WAIT)
//   accept                IDLE is taking a legal access this cycle
//   complete              WAIT saw a clean mem_done this cycle
//   stall_out             freeze upstream stages / hold EX/MEM
//   err                   sticky error, registered
module mem_req_fsm
  import mem_stage_defs::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic mem_read,
  input  logic mem_write,
  input  logic addr_lsb,
  input  logic mem_done,
  input  logic mem_err,
  output logic accept,
  output logic complete,
  output logic stall_out,
  output logic err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             timeout_s;
  logic             stall_s;
  logic             accept_s;
  logic             complete_s;
  logic             err_r;

  assign timeout_s = (wait_cnt_r == CNT_LAST);

  // Next-state and per-state control decode.
  always_comb begin
    state_next_s = state_r;
    stall_s      = 1'b0;
    accept_s     = 1'b0;
    complete_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (valid && (mem_read || mem_write)) begin
          // Hold EX/MEM in the presentation cycle, legal or not.
          stall_s = 1'b1;
          if (access_ok(mem_read, mem_write, addr_lsb)) begin
            accept_s     = 1'b1;
            state_next_s = ST_REQ;
          end else begin
            state_next_s = ST_ERR;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        stall_s      = 1'b1;
        state_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        stall_s = 1'b1;
        // mem_done is checked before the timeout so a response landing on
        // the last allowed cycle still completes normally.
        if (mem_done) begin
          if (mem_err) begin
            state_next_s = ST_ERR;
          end else begin
            complete_s   = 1'b1;
            state_next_s = ST_DONE;
          end
        end else if (timeout_s) begin
          state_next_s = ST_ERR;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      ST_ERR: begin
        stall_s      = 1'b1;
        state_next_s = ST_ERR;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Stall is forced low while reset is asserted so the pipeline can flush.
  assign stall_out = stall_s & ~rst;
  assign accept    = accept_s;
  assign complete  = complete_s;
  assign err       = err_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // WAIT-cycle counter: cleared while in REQ, counts each WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= '0;
    end else if (state_r == ST_REQ) begin
      wait_cnt_r <= '0;
    end else if (state_r == ST_WAIT) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Sticky error flag, set on entry to ERR and held until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= (state_next_s == ST_ERR);
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: accepts one load/store from EX/MEM, issues a single
// strobe to memory from registered address/data, waits for the response and
// hands load data to MEM/WB.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   valid, addr, wdata,
//   MemRead, MemWrite            EX/MEM instruction
//   mem_rd, mem_wr,
//   mem_addr, mem_wdata          registered memory request
//   mem_rdata, mem_done, mem_err memory response
//   stall_out                    freeze IF/ID/EX, hold EX/MEM
//   rdata_out, rdata_valid       load result to MEM/WB
//   err                          sticky stage error
module mem_stage
  import mem_stage_defs::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  input  logic        mem_err,
  output logic        stall_out,
  output logic [15:0] rdata_out,
  output logic        rdata_valid,
  output logic        err
);

  logic accept_s;
  logic complete_s;
  logic is_load_r;

  mem_req_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .valid    (valid),
    .mem_read (MemRead),
    .mem_write(MemWrite),
    .addr_lsb (addr[0]),
    .mem_done (mem_done),
    .mem_err  (mem_err),
    .accept   (accept_s),
    .complete (complete_s),
    .stall_out(stall_out),
    .err      (err)
  );

  // Request capture and one-cycle strobe generation; the strobe lands in the
  // REQ cycle because it is registered on the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
      is_load_r <= 1'b0;
    end else begin
      mem_rd <= accept_s & MemRead;
      mem_wr <= accept_s & MemWrite;
      if (accept_s) begin
        mem_addr  <= addr;
        mem_wdata <= wdata;
        is_load_r <= MemRead;
      end
    end
  end

  // Load result: data held until the next load completes, valid for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_out   <= 16'h0000;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= complete_s & is_load_r;
      if (complete_s && is_load_r) begin
        rdata_out <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam int MAXC = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        MemRead;
  logic        MemWrite;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        mem_err;
  logic        stall_out;
  logic [15:0] rdata_out;
  logic        rdata_valid;
  logic        err;

  int errors = 0;
  int checks = 0;
  logic [15:0] last_rdata;

  // d: mem_done arrives d cycles after the strobe (0 = never)
  // exp_strobe_c / exp_err_c: cycle index (0 = presentation) or -1 for never
  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          d;
    logic        eresp;
    int          exp_stall;
    int          exp_rd;
    int          exp_wr;
    int          exp_rv;
    int          exp_strobe_c;
    int          exp_err_c;
  } vec_t;

  vec_t vecs[11];
  vec_t sb_q[$];

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .addr       (addr),
    .wdata      (wdata),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_done   (mem_done),
    .mem_err    (mem_err),
    .stall_out  (stall_out),
    .rdata_out  (rdata_out),
    .rdata_valid(rdata_valid),
    .err        (err)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_rd"}, int'(mem_rd), 0);
    chk({tag, "_mem_wr"}, int'(mem_wr), 0);
    chk({tag, "_mem_addr"}, int'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, int'(mem_wdata), 0);
    chk({tag, "_rdata_out"}, int'(rdata_out), 0);
    chk({tag, "_rdata_valid"}, int'(rdata_valid), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_stall"}, int'(stall_out), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    mem_done = 1'b0; mem_err = 1'b0;
    @(negedge clk);
    chk("stall_during_reset", int'(stall_out), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");
    last_rdata = 16'h0000;
  endtask

  task automatic run_vec(input vec_t v);
    int stall_n, rd_n, wr_n, rv_n, ovl_n, strobe_c, err_c;
    logic [15:0] s_addr, s_wdata, rv_data;
    bit stop;
    vec_t e;
    stall_n = 0; rd_n = 0; wr_n = 0; rv_n = 0; ovl_n = 0;
    strobe_c = -1; err_c = -1; stop = 1'b0;
    s_addr = 16'h0; s_wdata = 16'h0; rv_data = 16'h0;
    sb_q.push_back(v);
    for (int c = 0; c < MAXC && !stop; c++) begin
      @(posedge clk); #1;
      valid = 1'b1; MemRead = v.rd; MemWrite = v.wr; addr = v.addr; wdata = v.wdata;
      if (v.d != 0 && c == v.d + 1) begin
        mem_done = 1'b1; mem_rdata = v.rdata; mem_err = v.eresp;
      end else if (c == 0) begin
        // stray response while idle must be ignored
        mem_done = 1'b1; mem_rdata = 16'hDEAD; mem_err = 1'b1;
      end else begin
        mem_done = 1'b0; mem_rdata = 16'h0000; mem_err = 1'b0;
      end
      @(negedge clk);
      if (stall_out) stall_n++;
      if (mem_rd) rd_n++;
      if (mem_wr) wr_n++;
      if (mem_rd && mem_wr) ovl_n++;
      if ((mem_rd || mem_wr) && strobe_c < 0) begin
        strobe_c = c; s_addr = mem_addr; s_wdata = mem_wdata;
      end
      if (rdata_valid) begin
        rv_n++; rv_data = rdata_out;
      end
      if (err && err_c < 0) err_c = c;
      if (!stall_out) stop = 1'b1;
    end
    e = sb_q.pop_front();
    chk("stall_cycles", stall_n, e.exp_stall);
    chk("rd_pulses", rd_n, e.exp_rd);
    chk("wr_pulses", wr_n, e.exp_wr);
    chk("strobe_overlap", ovl_n, 0);
    chk("rdata_valid_pulses", rv_n, e.exp_rv);
    chk("strobe_cycle", strobe_c, e.exp_strobe_c);
    chk("err_cycle", err_c, e.exp_err_c);
    if (e.exp_rv != 0) begin
      chk("load_data", int'(rv_data), int'(e.rdata));
      last_rdata = e.rdata;
    end
    chk("rdata_out_hold", int'(rdata_out), int'(last_rdata));
    if (e.exp_strobe_c >= 0) begin
      chk("mem_addr", int'(s_addr), int'(e.addr));
      chk("mem_wdata", int'(s_wdata), int'(e.wdata));
    end
    if (e.exp_err_c >= 0) begin
      do_reset();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //          rd    wr    addr      wdata     rdata     d  eresp stall rd wr rv strb errc
    vecs[0]  = '{1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0000, 0, 1'b0, 0,    0, 0, 0, -1, -1};
    vecs[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 2, 1'b0, 4,    1, 0, 1,  1, -1};
    vecs[2]  = '{1'b0, 1'b1, 16'h0020, 16'h1234, 16'h0000, 1, 1'b0, 3,    0, 1, 0,  1, -1};
    vecs[3]  = '{1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'h5A5A, 1, 1'b0, 3,    1, 0, 1,  1, -1};
    vecs[4]  = '{1'b1, 1'b0, 16'h0030, 16'h0000, 16'hC0DE, 4, 1'b0, 6,    1, 0, 1,  1, -1};
    vecs[5]  = '{1'b0, 1'b1, 16'h0040, 16'hA5A5, 16'h0000, 3, 1'b0, 5,    0, 1, 0,  1, -1};
    vecs[6]  = '{1'b1, 1'b0, 16'h0050, 16'h0000, 16'h0000, 0, 1'b0, MAXC, 1, 0, 0,  1,  6};
    vecs[7]  = '{1'b1, 1'b0, 16'h0011, 16'h0000, 16'h0000, 1, 1'b0, MAXC, 0, 0, 0, -1,  1};
    vecs[8]  = '{1'b1, 1'b1, 16'h0060, 16'h0000, 16'h0000, 1, 1'b0, MAXC, 0, 0, 0, -1,  1};
    vecs[9]  = '{1'b1, 1'b0, 16'h0070, 16'h0000, 16'h9999, 1, 1'b1, MAXC, 1, 0, 0,  1,  3};
    vecs[10] = '{1'b1, 1'b0, 16'h0080, 16'h0000, 16'h1111, 2, 1'b0, 4,    1, 0, 1,  1, -1};

    rst = 1'b1; valid = 1'b0; addr = 16'h0; wdata = 16'h0;
    MemRead = 1'b0; MemWrite = 1'b0;
    mem_rdata = 16'h0; mem_done = 1'b0; mem_err = 1'b0;
    last_rdata = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("stall_in_reset", int'(stall_out), 0);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("initial");

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i]);
    end

    // Reset during WAIT followed by a late mem_done.
    @(posedge clk); #1;
    valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; addr = 16'h0090;
    mem_done = 1'b0; mem_err = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_strobe_issued", int'(mem_rd), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_stall_in_reset", int'(stall_out), 0);
    @(posedge clk); #1;
    rst = 1'b0; valid = 1'b0; MemRead = 1'b0;
    mem_done = 1'b1; mem_rdata = 16'h7777;
    @(negedge clk);
    check_reset_outputs("abort");
    @(posedge clk); #1;
    mem_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_rdata_valid", int'(rdata_valid), 0);
      chk("abort_rdata_out", int'(rdata_out), 0);
      chk("abort_stall", int'(stall_out), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
